priority_table_loader: RTL and testbench

- Upstream configuration stage for priority_arbiter. Programs every per-peripheral entry of the arbiter's priority memory over its valid/ready memory interface.
- Each run is triggered by a single start pulse. An optional readback pass then verifies every entry.
- Replaces hand-sequenced testbench/CPU writes with a deterministic FSM. Reports busy, done and mismatch status to the controlling logic.

---
 rtl/priority_table_loader.sv | 135 +++++++++++++
 tb/tb_priority_table_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_table_loader.sv
// Programs every entry of the priority_arbiter priority memory from a shadowed
// configuration table, with an optional readback/compare pass.
module priority_table_loader #(
    parameter int NUM_PERIPH = 4,
    parameter int PRIO_W     = 4,
    parameter int IDX_W      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         verify_en,
    input  logic                         abort,
    input  logic [NUM_PERIPH*PRIO_W-1:0] cfg_priorities,
    output logic                         mem_valid,
    output logic                         mem_wr_rd,
    output logic [IDX_W-1:0]             mem_index,
    output logic [PRIO_W-1:0]            mem_wdata,
    input  logic                         mem_ready,
    input  logic [PRIO_W-1:0]            mem_rdata,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [IDX_W-1:0]             err_index
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PERIPH - 1);

    state_t                         r_state;
    state_t                         w_next;
    logic [IDX_W-1:0]               r_cnt;
    logic [NUM_PERIPH*PRIO_W-1:0]   r_shadow;
    logic                           r_verify;
    logic                           r_error;
    logic [IDX_W-1:0]               r_err_index;

    logic                           w_active;
    logic                           w_hs;
    logic                           w_last;
    logic                           w_mismatch;
    logic [PRIO_W-1:0]              w_cur;

    // Loop-based select keeps the index width independent of NUM_PERIPH.
    always_comb begin
        w_cur = '0;
        for (int unsigned i = 0; i < NUM_PERIPH; i++) begin
            if (r_cnt == IDX_W'(i)) begin
                w_cur = r_shadow[i*PRIO_W +: PRIO_W];
            end
        end
    end

    assign w_active   = (r_state == S_WRITE) || (r_state == S_READ);
    assign w_hs       = w_active & mem_ready;
    assign w_last     = (r_cnt == LAST_IDX);
    assign w_mismatch = (mem_rdata != w_cur);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_WRITE;
            end
            S_WRITE: begin
                if (abort)               w_next = S_IDLE;
                else if (w_hs && w_last) w_next = r_verify ? S_READ : S_DONE;
            end
            S_READ: begin
                if (abort)                             w_next = S_IDLE;
                else if (w_hs && (w_mismatch || w_last)) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_valid = w_active;
        busy      = w_active;
        mem_wr_rd = (r_state == S_WRITE);
        mem_index = w_active ? r_cnt : '0;
        mem_wdata = (r_state == S_WRITE) ? w_cur : '0;
        done      = (r_state == S_DONE);
        error     = r_error;
        err_index = r_err_index;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_verify    <= 1'b0;
            r_error     <= 1'b0;
            r_err_index <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shadow    <= cfg_priorities;
                        r_verify    <= verify_en;
                        r_error     <= 1'b0;
                        r_err_index <= '0;
                        r_cnt       <= '0;
                    end
                end
                S_WRITE: begin
                    if (w_hs) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                end
                S_READ: begin
                    // An abort leaves the sticky error untouched even if a read completes with it.
                    if (w_hs && !abort) begin
                        if (w_mismatch) begin
                            r_error     <= 1'b1;
                            r_err_index <= r_cnt;
                        end else begin
                            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_priority_table_loader.sv
// Randomized bench for priority_table_loader against a transaction-list reference
// model and an echoing arbiter memory model.
module tb_priority_table_loader;

    localparam int N  = 4;
    localparam int PW = 4;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            verify_en;
    logic            abort;
    logic [N*PW-1:0] cfg_priorities;
    logic            mem_valid;
    logic            mem_wr_rd;
    logic [IW-1:0]   mem_index;
    logic [PW-1:0]   mem_wdata;
    logic            mem_ready;
    logic [PW-1:0]   mem_rdata;
    logic            busy;
    logic            done;
    logic            error;
    logic [IW-1:0]   err_index;

    logic [PW-1:0]   mem_model [16];
    logic            bad_en;
    logic [IW-1:0]   bad_idx;
    logic [PW-1:0]   bad_val;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    priority_table_loader #(
        .NUM_PERIPH(N),
        .PRIO_W(PW),
        .IDX_W(IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .verify_en(verify_en),
        .abort(abort),
        .cfg_priorities(cfg_priorities),
        .mem_valid(mem_valid),
        .mem_wr_rd(mem_wr_rd),
        .mem_index(mem_index),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .busy(busy),
        .done(done),
        .error(error),
        .err_index(err_index)
    );

    // Arbiter memory: echoes what was written, optionally corrupting one entry.
    assign mem_rdata = (bad_en && mem_index == bad_idx) ? bad_val : mem_model[mem_index];

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int enc(input int wr, input int idx, input int data);
        return (wr << 8) | (idx << 4) | data;
    endfunction

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 3) == 1;
            2:       return $urandom_range(0, 3) != 0;
            default: return cyc == 1;
        endcase
    endfunction

    // abort_at > 0 asserts abort in that cycle (cycle 1 = first cycle after start edge).
    task automatic run_load(input logic [N*PW-1:0] tbl, input logic ver, input int mode,
                            input logic bad, input int bidx, input logic [PW-1:0] bval,
                            input int abort_at);
        int          exp_q[$];
        int          exp_err;
        int          exp_eidx;
        int          hs;
        int          cyc;
        int          done_cyc;
        int          last_hs;
        int          entry;
        int          rd;

        exp_err  = 0;
        exp_eidx = 0;
        for (int i = 0; i < N; i++) exp_q.push_back(enc(1, i, int'(tbl[i*PW +: PW])));
        if (ver) begin
            for (int i = 0; i < N; i++) begin
                entry = int'(tbl[i*PW +: PW]);
                rd    = (bad && i == bidx) ? int'(bval) : entry;
                exp_q.push_back(enc(0, i, 0));
                if (rd != entry) begin
                    exp_err  = 1;
                    exp_eidx = i;
                    break;
                end
            end
        end

        bad_en  = bad;
        bad_idx = IW'(bidx);
        bad_val = bval;

        @(posedge clk); #1;
        cfg_priorities = tbl;
        verify_en      = ver;
        start          = 1'b1;
        abort          = 1'b0;
        mem_ready      = 1'b0;

        cyc      = 0;
        hs       = 0;
        done_cyc = -1;
        last_hs  = -1;
        while (cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            start          = (abort_at == 0 || cyc <= abort_at) ? 1'($urandom_range(0, 1)) : 1'b0;
            cfg_priorities = N*PW'($urandom);
            verify_en      = 1'($urandom_range(0, 1));
            abort          = (cyc == abort_at);
            mem_ready      = ready_for(mode, cyc);
            @(negedge clk);
            if (mem_valid) begin
                check("busy_in_xfer", int'(busy), 1);
                if (hs < exp_q.size())
                    check("xfer", enc(int'(mem_wr_rd), int'(mem_index), int'(mem_wdata)), exp_q[hs]);
                else
                    check("extra_xfer", 1, 0);
                if (mem_ready) begin
                    if (mem_wr_rd) mem_model[mem_index] = mem_wdata;
                    hs++;
                    last_hs = cyc;
                end
            end
            if (abort_at > 0 && cyc == abort_at + 1) begin
                check("abort_valid", int'(mem_valid), 0);
                check("abort_busy", int'(busy), 0);
                break;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;

        if (abort_at > 0) begin
            check("abort_hs_count", hs, 1);
            repeat (3) begin
                @(negedge clk);
                check("no_done_after_abort", int'(done), 0);
            end
        end else begin
            check("done_seen", int'(done_cyc > 0), 1);
            check("hs_count", hs, exp_q.size());
            check("done_after_last_hs", done_cyc, last_hs + 1);
            if (mode == 0) check("done_latency", done_cyc, exp_q.size() + 1);
            check("error", int'(error), exp_err);
            check("err_index", int'(err_index), exp_eidx);
            @(negedge clk);
            check("done_width", int'(done), 0);
            check("idle_valid", int'(mem_valid), 0);
            check("error_held", int'(error), exp_err);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, enc(int'(mem_valid), int'(mem_index), int'(mem_wdata)) |
                   (int'(mem_wr_rd) << 12) | (int'(busy) << 13) | (int'(done) << 14) |
                   (int'(error) << 15) | (int'(err_index) << 16), 0);
    endtask

    initial begin
        logic [N*PW-1:0] tbl;
        logic [PW-1:0]   ent;
        int              bi;

        for (int i = 0; i < 16; i++) mem_model[i] = '0;
        rst            = 1'b1;
        start          = 1'b0;
        verify_en      = 1'b0;
        abort          = 1'b0;
        cfg_priorities = '0;
        mem_ready      = 1'b0;
        bad_en         = 1'b0;
        bad_idx        = '0;
        bad_val        = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_outputs");
        @(posedge clk); #1;
        rst = 1'b0;

        // entry0=3, entry1=1, entry2=2, entry3=0
        tbl = 16'h0213;
        run_load(tbl, 1'b0, 0, 1'b0, 0, 4'd0, 0);
        run_load(tbl, 1'b0, 1, 1'b0, 0, 4'd0, 0);
        run_load(tbl, 1'b1, 0, 1'b0, 0, 4'd0, 0);
        run_load(tbl, 1'b1, 0, 1'b1, 2, 4'd5, 0);
        run_load(tbl, 1'b0, 0, 1'b0, 0, 4'd0, 0);
        run_load(16'h9ab7, 1'b0, 3, 1'b0, 0, 4'd0, 2);
        run_load(tbl, 1'b1, 1, 1'b0, 0, 4'd0, 0);

        // Reset mid-load with a sticky error pending.
        run_load(tbl, 1'b1, 0, 1'b1, 1, 4'd7, 0);
        @(posedge clk); #1;
        cfg_priorities = 16'h4321;
        verify_en      = 1'b1;
        start          = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("rst_midload");
        run_load(16'h4321, 1'b1, 0, 1'b0, 0, 4'd0, 0);

        for (int k = 0; k < 8; k++) begin
            tbl = N*PW'($urandom);
            bi  = $urandom_range(0, N - 1);
            ent = tbl[bi*PW +: PW];
            run_load(tbl, 1'($urandom_range(0, 1)), (k % 2 == 0) ? 0 : 2,
                     1'($urandom_range(0, 1)), bi, ent ^ PW'($urandom_range(1, 15)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
